// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one external combinational ALU between two
// requesters: registers the winner's operands, captures the ALU outputs a cycle later
// and returns them through a valid/ready response tagged with the requester id.
module alu_arbiter #(
   parameter int DATA_W = 32,
   parameter int SH_W   = 5,
   parameter int OP_W   = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [SH_W-1:0]   req0_sh_amt,
   input  logic [OP_W-1:0]   req0_op,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [SH_W-1:0]   req1_sh_amt,
   input  logic [OP_W-1:0]   req1_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [SH_W-1:0]   alu_sh_amt,
   output logic [OP_W-1:0]   alu_op,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_neg,
   input  logic              alu_zero,
   input  logic              alu_carry,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_neg,
   output logic              rsp_zero,
   output logic              rsp_carry,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic   rr_ptr;
   logic   id_q;
   logic   grant0, grant1;
   logic   xfer;

   // rr_ptr names the requester that wins when both are valid at once.
   always_comb begin
      grant0 = req0_valid & (~req1_valid | ~rr_ptr);
      grant1 = req1_valid & (~req0_valid |  rr_ptr);
   end

   assign req0_ready = (state == IDLE) & grant0;
   assign req1_ready = (state == IDLE) & grant1;
   assign xfer       = req0_ready | req1_ready;
   assign busy       = (state != IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (xfer) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Operands are latched only on a transfer so the ALU sees a stable operation
   // no matter what the requesters drive afterwards.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr     <= 1'b0;
         id_q       <= 1'b0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_sh_amt <= '0;
         alu_op     <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_neg    <= 1'b0;
         rsp_zero   <= 1'b0;
         rsp_carry  <= 1'b0;
      end else begin
         if (xfer) begin
            rr_ptr     <= ~grant1;
            id_q       <= grant1;
            alu_a      <= grant1 ? req1_a      : req0_a;
            alu_b      <= grant1 ? req1_b      : req0_b;
            alu_sh_amt <= grant1 ? req1_sh_amt : req0_sh_amt;
            alu_op     <= grant1 ? req1_op     : req0_op;
         end
         if (state == EXEC) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= id_q;
            rsp_result <= alu_result;
            rsp_neg    <= alu_neg;
            rsp_zero   <= alu_zero;
            rsp_carry  <= alu_carry;
         end else if (state == RESP && rsp_ready) begin
            rsp_valid  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a bench-side ALU stub plus a transaction-level
// model of grant order, operand latching and response timing.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [4:0]  req0_sh_amt, req1_sh_amt;
   logic [2:0]  req0_op, req1_op;
   logic [31:0] alu_a, alu_b, alu_result;
   logic [4:0]  alu_sh_amt;
   logic [2:0]  alu_op;
   logic        alu_neg, alu_zero, alu_carry;
   logic        rsp_valid, rsp_ready, rsp_id;
   logic [31:0] rsp_result;
   logic        rsp_neg, rsp_zero, rsp_carry;
   logic        busy;
   logic [34:0] stub;

   int   passed = 0;
   int   total  = 0;
   logic prio   = 1'b0;

   always #5 clk = ~clk;

   alu_arbiter #(.DATA_W(32), .SH_W(5), .OP_W(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_sh_amt(req0_sh_amt), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_sh_amt(req1_sh_amt), .req1_op(req1_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sh_amt(alu_sh_amt), .alu_op(alu_op),
      .alu_result(alu_result), .alu_neg(alu_neg), .alu_zero(alu_zero), .alu_carry(alu_carry),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
      .rsp_neg(rsp_neg), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .busy(busy)
   );

   // Returns {carry, neg, zero, result}; op0 add, op1 subtract (carry = no borrow).
   function automatic logic [34:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] sh, input logic [2:0] op);
      logic [32:0] s;
      case (op)
         3'd0:    s = {1'b0, a} + {1'b0, b};
         3'd1:    s = {1'b0, a} + {1'b0, ~b} + 33'd1;
         3'd2:    s = {1'b0, a & b};
         3'd3:    s = {1'b0, a | b};
         3'd4:    s = {1'b0, a ^ b};
         3'd5:    s = {1'b0, a << sh};
         3'd6:    s = {1'b0, a >> sh};
         default: s = {1'b0, b};
      endcase
      return {s[32], s[31], (s[31:0] == 32'd0), s[31:0]};
   endfunction

   always_comb stub = alu_ref(alu_a, alu_b, alu_sh_amt, alu_op);
   assign alu_result = stub[31:0];
   assign alu_zero   = stub[32];
   assign alu_neg    = stub[33];
   assign alu_carry  = stub[34];

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected) passed++;
      else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
   endtask

   task automatic applyStimulus(input logic v0, input logic v1,
                                input logic [31:0] a0, input logic [31:0] b0,
                                input logic [31:0] a1, input logic [31:0] b1,
                                input logic [4:0] s0, input logic [4:0] s1,
                                input logic [2:0] o0, input logic [2:0] o1);
      req0_valid = v0; req0_a = a0; req0_b = b0; req0_sh_amt = s0; req0_op = o0;
      req1_valid = v1; req1_a = a1; req1_b = b1; req1_sh_amt = s1; req1_op = o1;
   endtask

   task automatic scrambleInputs();
      applyStimulus(1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom,
                    5'($urandom), 5'($urandom), 3'($urandom), 3'($urandom));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      prio = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready  = 1'b1;
      for (int i = 0; i < n; i++) begin
         tick();
         checkOutput("idle_rsp_valid", rsp_valid, 0);
         checkOutput("idle_busy", busy, 0);
      end
   endtask

   // One complete operation: grant, latch, response, optional back-pressure, retire.
   task automatic doOp(input logic v0, input logic v1,
                       input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] a1, input logic [31:0] b1,
                       input logic [4:0] s0, input logic [4:0] s1,
                       input logic [2:0] o0, input logic [2:0] o1,
                       input int stall, input logic scramble);
      logic        g;
      logic [31:0] ea, eb;
      logic [4:0]  es;
      logic [2:0]  eo;
      logic [34:0] er;
      applyStimulus(v0, v1, a0, b0, a1, b1, s0, s1, o0, o1);
      rsp_ready = (stall == 0);
      g  = (v0 && v1) ? prio : (v0 ? 1'b0 : 1'b1);
      ea = g ? a1 : a0;
      eb = g ? b1 : b0;
      es = g ? s1 : s0;
      eo = g ? o1 : o0;
      er = alu_ref(ea, eb, es, eo);
      #3;
      checkOutput("grant_req0_ready", req0_ready, g == 1'b0);
      checkOutput("grant_req1_ready", req1_ready, g == 1'b1);
      checkOutput("grant_busy", busy, 0);
      tick();
      prio = ~g;
      checkOutput("exec_alu_a", alu_a, ea);
      checkOutput("exec_alu_b", alu_b, eb);
      checkOutput("exec_alu_sh", alu_sh_amt, es);
      checkOutput("exec_alu_op", alu_op, eo);
      checkOutput("exec_busy", busy, 1);
      checkOutput("exec_rsp_valid", rsp_valid, 0);
      if (scramble) scrambleInputs();
      #3;
      checkOutput("exec_no_ready", {req1_ready, req0_ready}, 0);
      tick();
      checkOutput("rsp_valid", rsp_valid, 1);
      checkOutput("rsp_id", rsp_id, g);
      checkOutput("rsp_result", rsp_result, er[31:0]);
      checkOutput("rsp_flags", {rsp_carry, rsp_neg, rsp_zero}, er[34:32]);
      checkOutput("rsp_alu_a_held", alu_a, ea);
      for (int i = 0; i < stall; i++) begin
         if (scramble) scrambleInputs();
         #3;
         checkOutput("stall_no_ready", {req1_ready, req0_ready}, 0);
         tick();
         checkOutput("stall_rsp_valid", rsp_valid, 1);
         checkOutput("stall_rsp_result", rsp_result, er[31:0]);
         checkOutput("stall_rsp_id", rsp_id, g);
         checkOutput("stall_busy", busy, 1);
      end
      rsp_ready  = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();
      checkOutput("retire_rsp_valid", rsp_valid, 0);
      checkOutput("retire_busy", busy, 0);
      checkOutput("retire_alu_a_held", alu_a, ea);
   endtask

   // Transfer from one requester, then reset while in EXEC (phase 1) or RESP (phase 2).
   task automatic resetDuring(input int phase, input logic who);
      applyStimulus(~who, who, 32'd1, 32'd1, 32'd1, 32'd1, 5'd0, 5'd0, 3'd0, 3'd0);
      rsp_ready = 1'b0;
      #3;
      checkOutput("rst_grant", {req1_ready, req0_ready}, who ? 2 : 1);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      if (phase == 2) begin
         tick();
         checkOutput("rst_pre_rsp_valid", rsp_valid, 1);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      prio  = 1'b0;
      checkOutput("rst_rsp_valid", rsp_valid, 0);
      checkOutput("rst_alu_a", alu_a, 0);
      checkOutput("rst_alu_b", alu_b, 0);
      checkOutput("rst_busy", busy, 0);
      idleCycles(4);
   endtask

   initial begin
      rsp_ready = 1'b0;
      applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, 5'd0, 5'd0, 3'd0, 3'd0);
      doReset();
      checkOutput("reset_alu_a", alu_a, 0);
      checkOutput("reset_alu_b", alu_b, 0);
      checkOutput("reset_alu_sh_op", {alu_sh_amt, alu_op}, 0);
      checkOutput("reset_rsp_valid", rsp_valid, 0);
      checkOutput("reset_rsp_fields", {rsp_id, rsp_neg, rsp_zero, rsp_carry}, 0);
      checkOutput("reset_rsp_result", rsp_result, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_ready", {req1_ready, req0_ready}, 0);

      $display("[TB] single operation -54 + 54");
      doOp(1'b1, 1'b0, 32'hFFFF_FFCA, 32'd54, 32'd0, 32'd0, 5'd0, 5'd0, 3'd0, 3'd0, 0, 1'b0);
      checkOutput("single_result", rsp_result, 0);
      checkOutput("single_zero_carry_neg", {rsp_zero, rsp_carry, rsp_neg}, 3'b110);

      $display("[TB] contention from reset");
      doReset();
      for (int i = 0; i < 4; i++) begin
         doOp(1'b1, 1'b1, 32'd5, 32'd3, 32'd5, 32'd3, 5'd0, 5'd0, 3'd1, 3'd1, 0, 1'b0);
         checkOutput("contention_result", rsp_result, 2);
         checkOutput("contention_id", rsp_id, i % 2);
      end

      $display("[TB] back-pressure stall of 10 cycles");
      doOp(1'b0, 1'b1, 32'd0, 32'd0, $urandom, $urandom, 5'd0, 5'($urandom), 3'd0, 3'($urandom),
           10, 1'b1);

      $display("[TB] randomized operations");
      for (int i = 0; i < 30; i++) begin
         logic v0, v1;
         v0 = 1'($urandom);
         v1 = v0 ? 1'($urandom) : 1'b1;
         doOp(v0, v1, $urandom, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom),
              3'($urandom), 3'($urandom), $urandom_range(0, 3), 1'b1);
         if (i % 7 == 0) idleCycles(2);
      end

      $display("[TB] reset during EXEC and RESP");
      resetDuring(1, 1'b1);
      doOp(1'b1, 1'b1, 32'd9, 32'd4, 32'd7, 32'd7, 5'd0, 5'd0, 3'd1, 3'd1, 0, 1'b0);
      checkOutput("after_rst1_id", rsp_id, 0);
      resetDuring(2, 1'b0);
      doOp(1'b1, 1'b1, 32'd9, 32'd4, 32'd7, 32'd7, 5'd0, 5'd0, 3'd1, 3'd1, 0, 1'b0);
      checkOutput("after_rst2_id", rsp_id, 0);
      checkOutput("after_rst2_result", rsp_result, 5);

      $display("[TB] %0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
